dsp_result_drain: RTL

- Output-side counterpart of the DSP48A1 operand input registers: captures the 48-bit P result plus CARRYOUT from the slice.
- Buffers up to two results in a 2-entry FIFO.
- Serialises each result as three 18-bit beats onto a valid/ready bus for readback by the host/test logic.
- Sits after the P/CARRYOUT output registers of the DSP48A1 model.

---
 rtl/dsp_result_drain.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dsp_result_drain.sv
// Result drain for the DSP48A1 model: captures {CARRYOUT, P} into a 2-entry FIFO
// and serialises each word as three 18-bit beats on a valid/ready bus.
module dsp_result_drain #(
  parameter bit CARRY_EN  = 1'b1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        CLR,
  input  logic [47:0] P,
  input  logic        CARRYOUT,
  input  logic        PVALID,
  input  logic        CEP,
  output logic        PREADY,
  output logic [17:0] DOUT,
  output logic        DVALID,
  input  logic        DREADY,
  output logic        DLAST,
  output logic        OVERFLOW
);

  typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_B2} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [48:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [17:0] r_dout;
  logic [17:0] w_dout_nxt;
  logic        r_dlast;
  logic        w_dlast_nxt;
  logic        r_ovf;

  logic        w_pready;
  logic [48:0] w_wdata;
  logic        w_wr;
  logic        w_pop;
  logic [48:0] w_head;
  logic [48:0] w_next_head;
  logic        w_more;

  // Emission slot e (0..2) maps to a beat index; MSB_FIRST reverses the order.
  function automatic logic [17:0] beat_of(input logic [48:0] word, input logic [1:0] e);
    logic [1:0] idx;
    idx = MSB_FIRST ? (2'd2 - e) : e;
    case (idx)
      2'd0:    beat_of = word[17:0];
      2'd1:    beat_of = word[35:18];
      default: beat_of = {5'b0, word[48] & CARRY_EN, word[47:36]};
    endcase
  endfunction

  assign w_pready = RSTN && (r_count != 2'd2);
  assign w_wdata  = {CARRYOUT, P};
  assign w_wr     = PVALID & CEP & w_pready & ~CLR;
  assign w_pop    = (r_state == S_B2) & DREADY;
  assign w_head   = r_mem[r_rd_ptr];
  // After a pop the new head is either the second stored word or the word landing this edge.
  assign w_next_head = (r_count == 2'd2) ? r_mem[~r_rd_ptr] : w_wdata;
  assign w_more      = (r_count == 2'd2) | w_wr;

  // NOTE: storage has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ovf    <= 1'b0;
    end else if (CLR) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (PVALID && CEP && !w_pready) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_dout  <= 18'd0;
      r_dlast <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= w_dout_nxt;
      r_dlast <= w_dlast_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    if (CLR) begin
      w_state_nxt = S_IDLE;
      w_dout_nxt  = 18'd0;
    end else begin
      case (r_state)
        S_IDLE: if (r_count != 2'd0) begin
          w_state_nxt = S_B0;
          w_dout_nxt  = beat_of(w_head, 2'd0);
        end
        S_B0: if (DREADY) begin
          w_state_nxt = S_B1;
          w_dout_nxt  = beat_of(w_head, 2'd1);
        end
        S_B1: if (DREADY) begin
          w_state_nxt = S_B2;
          w_dout_nxt  = beat_of(w_head, 2'd2);
        end
        S_B2: if (DREADY) begin
          if (w_more) begin
            w_state_nxt = S_B0;
            w_dout_nxt  = beat_of(w_next_head, 2'd0);
          end else begin
            w_state_nxt = S_IDLE;
            w_dout_nxt  = 18'd0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_dlast_nxt = (w_state_nxt == S_B2);
  end

  assign PREADY   = w_pready;
  assign DOUT     = r_dout;
  assign DVALID   = (r_state != S_IDLE);
  assign DLAST    = r_dlast;
  assign OVERFLOW = r_ovf;

endmodule
